// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the configuration-chain transmitter.
// CFG_STREAM_TX_PARITY_EN adds a trailing even-parity bit after the payload.
`timescale 1ns/1ps
package cfg_pkg;

`ifdef CFG_STREAM_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, HDR, PAY, PAR, DONE} tx_state_t;
  localparam int unsigned PAR_BITS = 1;
`else
  typedef enum logic [2:0] {IDLE, FETCH, HDR, PAY, DONE} tx_state_t;
  localparam int unsigned PAR_BITS = 0;
`endif

  localparam int unsigned DEF_ID_WIDTH   = 3;
  localparam int unsigned DEF_CFG_SIZE   = 256;
  localparam int unsigned DEF_WORD_WIDTH = 32;

  function automatic int unsigned calc_nw(int unsigned cfg_size, int unsigned word_width);
    return cfg_size / word_width;
  endfunction

  function automatic int unsigned calc_bit_cnt_w(int unsigned id_width, int unsigned word_width);
    return $clog2(((id_width > word_width) ? id_width : word_width) + 1);
  endfunction

  function automatic int unsigned calc_word_cnt_w(int unsigned nw);
    return $clog2(nw + 1);
  endfunction

  function automatic int unsigned frame_len(int unsigned id_width, int unsigned cfg_size);
    return id_width + cfg_size + PAR_BITS;
  endfunction

  localparam int unsigned NW         = calc_nw(DEF_CFG_SIZE, DEF_WORD_WIDTH);
  localparam int unsigned BIT_CNT_W  = calc_bit_cnt_w(DEF_ID_WIDTH, DEF_WORD_WIDTH);
  localparam int unsigned WORD_CNT_W = calc_word_cnt_w(NW);
  localparam int unsigned FRAME_LEN  = frame_len(DEF_ID_WIDTH, DEF_CFG_SIZE);

endpackage

// File: rtl/cfg_word_buf.sv
// One-entry prefetch register between the host word interface and the shifter.
`timescale 1ns/1ps
module cfg_word_buf #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             inv,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid
);

  // Invalidate wins over load so an abort cannot leave a stale word behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (inv) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      dout <= din;
    end
  end

endmodule

// File: rtl/cfg_stream_tx.sv
// Serial configuration transmitter: start strobe, MSB-first ID header, LSB-first payload.
// CFG_STREAM_TX_PARITY_EN appends an even-parity bit over the payload.
`timescale 1ns/1ps
module cfg_stream_tx
  import cfg_pkg::*;
#(
  parameter int unsigned ID_WIDTH   = DEF_ID_WIDTH,
  parameter int unsigned CFG_SIZE   = DEF_CFG_SIZE,
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  output logic                  cmd_ready,
  input  logic [WORD_WIDTH-1:0] word_data,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  cfg_out_start,
  output logic                  cfg_bit_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err_underrun
);

  localparam int unsigned N_WORDS = calc_nw(CFG_SIZE, WORD_WIDTH);
  localparam int unsigned BCW     = calc_bit_cnt_w(ID_WIDTH, WORD_WIDTH);
  localparam int unsigned WCW     = calc_word_cnt_w(N_WORDS);

  tx_state_t             state, state_n;
  logic [BCW-1:0]        bit_cnt, bit_cnt_n;
  logic [WCW-1:0]        word_cnt, word_cnt_n;
  logic [ID_WIDTH-1:0]   id_q, id_n;
  logic [WORD_WIDTH-1:0] sh, sh_n;
  logic                  bit_n, start_n, done_n, err_n;
  logic                  buf_valid, buf_inv, word_fire, need_word;
  logic [WORD_WIDTH-1:0] buf_data;
`ifdef CFG_STREAM_TX_PARITY_EN
  logic                  par_q, par_n;
`endif

  cfg_word_buf #(.WIDTH(WORD_WIDTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .load  (word_fire),
    .inv   (buf_inv),
    .din   (word_data),
    .dout  (buf_data),
    .valid (buf_valid)
  );

  assign busy = (state != IDLE);

  // Outputs are registered, so each state decides the bit shown in the next cycle.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    word_cnt_n = word_cnt;
    id_n       = id_q;
    sh_n       = sh;
    err_n      = err_underrun;
    bit_n      = 1'b0;
    start_n    = 1'b0;
    done_n     = 1'b0;
    buf_inv    = 1'b0;
    need_word  = 1'b0;
    cmd_ready  = (state == IDLE);
    word_ready = ((state == FETCH) || (state == HDR) || (state == PAY)) &&
                 !buf_valid && (word_cnt < WCW'(N_WORDS));
    word_fire  = word_valid && word_ready;
    if (word_fire) begin
      word_cnt_n = word_cnt + WCW'(1);
    end

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_n    = FETCH;
          id_n       = cmd_id;
          err_n      = 1'b0;
          word_cnt_n = '0;
        end
      end
      FETCH: begin
        if (buf_valid || word_fire) begin
          state_n   = HDR;
          start_n   = 1'b1;
          bit_n     = id_q[ID_WIDTH-1];
          id_n      = id_q << 1;
          bit_cnt_n = BCW'(1);
        end
      end
      HDR: begin
        if (bit_cnt < BCW'(ID_WIDTH)) begin
          bit_n     = id_q[ID_WIDTH-1];
          id_n      = id_q << 1;
          bit_cnt_n = bit_cnt + BCW'(1);
        end else begin
          need_word = 1'b1;
        end
      end
      PAY: begin
        if (bit_cnt < BCW'(WORD_WIDTH)) begin
          bit_n     = sh[0];
          sh_n      = sh >> 1;
          bit_cnt_n = bit_cnt + BCW'(1);
        end else if (buf_valid || (word_cnt != WCW'(N_WORDS))) begin
          need_word = 1'b1;
        end else begin
`ifdef CFG_STREAM_TX_PARITY_EN
          state_n = PAR;
          bit_n   = par_q;
`else
          state_n = DONE;
          done_n  = 1'b1;
`endif
        end
      end
`ifdef CFG_STREAM_TX_PARITY_EN
      PAR: begin
        state_n = DONE;
        done_n  = 1'b1;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Word boundary: hand the buffered word to the shifter or abort on underrun.
    if (need_word) begin
      buf_inv = 1'b1;
      if (buf_valid) begin
        state_n   = PAY;
        bit_n     = buf_data[0];
        sh_n      = buf_data >> 1;
        bit_cnt_n = BCW'(1);
      end else begin
        state_n = IDLE;
        err_n   = 1'b1;
      end
    end
  end

`ifdef CFG_STREAM_TX_PARITY_EN
  always_comb begin
    par_n = par_q;
    if (state == FETCH) begin
      par_n = 1'b0;
    end else if (state_n == PAY) begin
      par_n = par_q ^ bit_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_n;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      id_q          <= '0;
      sh            <= '0;
      cfg_bit_out   <= 1'b0;
      cfg_out_start <= 1'b0;
      done          <= 1'b0;
      err_underrun  <= 1'b0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      word_cnt      <= word_cnt_n;
      id_q          <= id_n;
      sh            <= sh_n;
      cfg_bit_out   <= bit_n;
      cfg_out_start <= start_n;
      done          <= done_n;
      err_underrun  <= err_n;
    end
  end

endmodule

// File: tb/tb_cfg_stream_tx.sv
// Self-checking bench for cfg_stream_tx with ID_WIDTH=3, CFG_SIZE=64, WORD_WIDTH=32.
// Follows CFG_STREAM_TX_PARITY_EN so it matches whichever build it is compiled with.
`timescale 1ns/1ps
module tb_cfg_stream_tx;

  localparam int IDW = 3;
  localparam int CS  = 64;
  localparam int WW  = 32;
  localparam int NW  = CS / WW;
`ifdef CFG_STREAM_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FL = IDW + CS + PB;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           cmd_valid = 1'b0;
  logic [IDW-1:0] cmd_id = '0;
  logic [WW-1:0]  word_data = '0;
  logic           word_valid = 1'b0;
  logic           cmd_ready, word_ready, cfg_out_start, cfg_bit_out, busy, done, err_underrun;

  int vectors = 0;
  int miscompares = 0;
  bit err_prev = 1'b0;

  typedef struct {
    logic [IDW-1:0] id;
    logic [WW-1:0]  w0;
    logic [WW-1:0]  w1;
    int             d0;
    int             d1;
    int             pre;
    bit             withhold;
    bit             hold;
    bit             b2b;
    int             exp_ones;
    int             exp_len;
  } vec_t;

  cfg_stream_tx #(.ID_WIDTH(IDW), .CFG_SIZE(CS), .WORD_WIDTH(WW)) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_id        (cmd_id),
    .cmd_ready     (cmd_ready),
    .word_data     (word_data),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .cfg_out_start (cfg_out_start),
    .cfg_bit_out   (cfg_bit_out),
    .busy          (busy),
    .done          (done),
    .err_underrun  (err_underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_start"}, cfg_out_start, 0);
    chk({tag, "_bit"}, cfg_bit_out, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_word_ready"}, word_ready, 0);
    chk({tag, "_err"}, err_underrun, 0);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
  endtask

  // Reference: the frame is the ID MSB-first, each word LSB-first, then optional parity,
  // one bit per cycle starting the cycle after the first word handshake.
  task automatic run_frame(input vec_t f);
    bit          es[$];
    logic [WW-1:0] w[NW];
    bit          par;
    bit          fin, e_busy, e_bit, e_err, e_start, e_done;
    int          t_acc, w_acc, tacc, widx, k, lim, ones, sc, dc;
    par = 1'b0; fin = 1'b0;
    t_acc = -1; w_acc = -1; tacc = 0; widx = 0; ones = 0; sc = -1; dc = -1;
    w[0] = f.w0;
    w[1] = f.w1;
    for (int i = IDW - 1; i >= 0; i--) es.push_back(f.id[i]);
    for (int j = 0; j < NW; j++) begin
      for (int b = 0; b < WW; b++) begin
        es.push_back(w[j][b]);
        par ^= w[j][b];
      end
    end
    if (PB != 0) es.push_back(par);
    lim = f.withhold ? (IDW + WW) : FL;

    for (int c = 0; c < 400 && !fin; c++) begin
      @(posedge clk); #1;
      k       = (w_acc < 0) ? -1 : c - (w_acc + 1);
      e_start = (k == 0);
      e_bit   = (k >= 0 && k < lim) ? es[k] : 1'b0;
      e_done  = !f.withhold && (k == FL);
      e_busy  = (t_acc >= 0) && ((w_acc < 0) || (f.withhold ? (k < lim) : (k <= FL)));
      e_err   = (t_acc >= 0) ? (f.withhold && k >= lim) : err_prev;
      chk("start", cfg_out_start, e_start);
      chk("bit", cfg_bit_out, e_bit);
      chk("done", done, e_done);
      chk("busy", busy, e_busy);
      chk("cmd_ready", cmd_ready, !e_busy);
      chk("err_underrun", err_underrun, e_err);
      if (!e_busy) chk("word_ready_idle", word_ready, 0);
      if (cfg_bit_out === 1'b1) ones++;
      if (cfg_out_start === 1'b1 && sc < 0) sc = c;
      if (done === 1'b1) dc = c;

      if (k == lim) begin
        fin        = 1'b1;
        cmd_valid  = 1'b0;
        word_valid = 1'b0;
      end else begin
        if (t_acc < 0) begin
          cmd_valid = (c >= f.pre);
          cmd_id    = f.id;
          if (cmd_valid && cmd_ready) t_acc = c;
        end else begin
          cmd_valid = f.hold;
          cmd_id    = ~f.id;
        end
        if (widx == 0) begin
          word_valid = (f.pre > 0) || (t_acc >= 0 && c > t_acc + f.d0);
          word_data  = w[0];
        end else if (widx < NW && !f.withhold) begin
          word_valid = (c > tacc + f.d1);
          word_data  = w[widx];
        end else begin
          word_valid = 1'b0;
        end
        if (word_valid && word_ready) begin
          if (widx == 0) w_acc = c;
          widx++;
          tacc = c;
        end
      end
    end

    chk("frame_complete", fin, 1);
    if (f.d0 == 0 && t_acc >= 0 && w_acc >= 0) chk("first_word_cycle", w_acc, t_acc + 1);
    if (f.b2b) chk("b2b_accept_cycle", t_acc, 0);
    if (f.exp_ones >= 0) chk("ones", ones, f.exp_ones);
    if (f.exp_len >= 0) chk("done_offset", dc - sc, f.exp_len);
    else chk("no_done", dc, -1);
    err_prev   = f.withhold;
    cmd_valid  = 1'b0;
    word_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl[6];
    vec_t f;

    tbl[0] = '{3'd5, 32'h0000_0001, 32'h8000_0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 4,      FL};
    tbl[1] = '{3'd4, 32'hFFFF_0000, 32'h0000_0000, 0, 0, 0, 1'b1, 1'b0, 1'b0, 17,     -1};
    tbl[2] = '{3'd0, 32'h0000_0007, 32'h0000_0000, 1, 3, 0, 1'b0, 1'b0, 1'b0, 3 + PB, FL};
    tbl[3] = '{3'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 0, 0, 0, 1'b0, 1'b1, 1'b0, 34,     FL};
    tbl[4] = '{3'd6, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 0, 1'b0, 1'b0, 1'b1, 35 + PB, FL};
    tbl[5] = '{3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 0, 2, 3, 1'b0, 1'b0, 1'b0, 33,     FL};

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("por");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_frame(tbl[i]);

    // Reset on the second header bit, then a fresh frame must be clean.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_id = 3'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("rst_seq_fetch_ready", word_ready, 1);
    word_valid = 1'b1; word_data = 32'hCAFE_F00D;
    @(posedge clk); #1;
    word_valid = 1'b0;
    chk("rst_seq_start", cfg_out_start, 1);
    chk("rst_seq_hdr1", cfg_bit_out, 1);
    @(posedge clk); #1;
    chk("rst_seq_hdr2", cfg_bit_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_values("midrst");
    err_prev = 1'b0;
    f = '{3'd2, 32'h0000_FFFF, 32'h0000_0000, 0, 0, 0, 1'b0, 1'b0, 1'b0, 17, FL};
    run_frame(f);

    for (int r = 0; r < 30; r++) begin
      f.id       = IDW'($urandom);
      f.w0       = $urandom;
      f.w1       = $urandom;
      f.d0       = int'($urandom_range(0, 4));
      f.d1       = int'($urandom_range(0, 15));
      f.pre      = int'($urandom_range(0, 2));
      f.withhold = ($urandom_range(0, 7) == 0);
      f.hold     = 1'($urandom_range(0, 1));
      f.b2b      = 1'b0;
      f.exp_ones = -1;
      f.exp_len  = f.withhold ? -1 : FL;
      run_frame(f);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
